// File: rtl/ysyx_22040632_dc_uncache_if.sv
// Bus bundle for the uncached data-access bridge: MEM-side request/response plus
// the five AXI4 channels. The bridge uses modport master; MEM + AXI slave use modport slave.
interface ysyx_22040632_dc_uncache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  // MEM side
  logic              valid;
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        size;
  logic [STRB_W-1:0] wmask_uncacheble;
  logic [DATA_W-1:0] data_write;
  logic              ready;
  logic [DATA_W-1:0] data_read;
  logic              err;

  // AXI read address / data
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [2:0]        ar_size;
  logic [7:0]        ar_len;
  logic [3:0]        ar_id;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;

  // AXI write address / data / response
  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [2:0]        aw_size;
  logic [7:0]        aw_len;
  logic [3:0]        aw_id;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              w_last;
  logic              b_valid;
  logic              b_ready;
  logic [1:0]        b_resp;

  modport master (
    input  valid, req, addr, size, wmask_uncacheble, data_write,
    output ready, data_read, err,
    output ar_valid, ar_addr, ar_size, ar_len, ar_id,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last,
    output r_ready,
    output aw_valid, aw_addr, aw_size, aw_len, aw_id,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready
  );

  modport slave (
    output valid, req, addr, size, wmask_uncacheble, data_write,
    input  ready, data_read, err,
    input  ar_valid, ar_addr, ar_size, ar_len, ar_id,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last,
    input  r_ready,
    input  aw_valid, aw_addr, aw_size, aw_len, aw_id,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready
  );
endinterface

// File: rtl/ysyx_22040632_dc_uncache.sv
// Uncached MEM->AXI4 bridge: one single-beat read or write per request, lane-shifted load data.
// Define YSYX_22040632_UNCACHE_RESP_CHK_EN to latch non-OKAY R/B responses into a sticky err flag.
module ysyx_22040632_dc_uncache #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 64,
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input logic                        clk,
  input logic                        rrst,
  ysyx_22040632_dc_uncache_if.master bus
);
  localparam int   STRB_W    = DATA_W / 8;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR_AW,
    WR_B,
    DONE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [STRB_W-1:0] wmask_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] data_read_q;
  logic              ar_valid_q;
  logic              r_ready_q;
  logic              aw_valid_q;
  logic              w_valid_q;
  logic              b_ready_q;
  logic              ready_q;
  logic              aw_done_q;
  logic              w_done_q;

  // Handshake flags including this cycle's handshake, so AW and W landing together count.
  logic aw_done_d;
  logic w_done_d;
  assign aw_done_d = aw_done_q | (aw_valid_q & bus.aw_ready);
  assign w_done_d  = w_done_q  | (w_valid_q  & bus.w_ready);

`ifdef YSYX_22040632_UNCACHE_RESP_CHK_EN
  logic err_q;
  logic unused_in;
  assign unused_in = bus.r_last;
`else
  logic unused_in;
  assign unused_in = ^{bus.r_last, bus.r_resp, bus.b_resp};
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rrst) begin
      state_q     <= IDLE;
      // NOTE: the latched payload is reset too, because it drives AXI address/data pins directly.
      addr_q      <= '0;
      size_q      <= '0;
      wmask_q     <= '0;
      wdata_q     <= '0;
      data_read_q <= '0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ready_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
`ifdef YSYX_22040632_UNCACHE_RESP_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.valid) begin
            addr_q  <= bus.addr;
            size_q  <= bus.size;
            wmask_q <= bus.wmask_uncacheble;
            wdata_q <= bus.data_write;
            if (bus.req == REQ_WRITE) begin
              state_q    <= WR_AW;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              aw_done_q  <= 1'b0;
              w_done_q   <= 1'b0;
            end else begin
              state_q    <= RD_A;
              ar_valid_q <= 1'b1;
            end
          end
        end
        RD_A: begin
          if (bus.ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= RD_D;
          end
        end
        RD_D: begin
          if (bus.r_valid) begin
            r_ready_q   <= 1'b0;
            data_read_q <= bus.r_data >> {addr_q[2:0], 3'b000};
            ready_q     <= 1'b1;
            state_q     <= DONE;
`ifdef YSYX_22040632_UNCACHE_RESP_CHK_EN
            if (bus.r_resp != 2'b00) err_q <= 1'b1;
`endif
          end
        end
        WR_AW: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (bus.aw_ready) aw_valid_q <= 1'b0;
          if (bus.w_ready)  w_valid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            b_ready_q <= 1'b1;
            state_q   <= WR_B;
          end
        end
        WR_B: begin
          if (bus.b_valid) begin
            b_ready_q <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= DONE;
`ifdef YSYX_22040632_UNCACHE_RESP_CHK_EN
            if (bus.b_resp != 2'b00) err_q <= 1'b1;
`endif
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.data_read = data_read_q;
`ifdef YSYX_22040632_UNCACHE_RESP_CHK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

  assign bus.ar_valid = ar_valid_q;
  assign bus.ar_addr  = addr_q;
  assign bus.ar_size  = size_q;
  assign bus.ar_len   = 8'd0;
  assign bus.ar_id    = AXI_ID;
  assign bus.r_ready  = r_ready_q;

  assign bus.aw_valid = aw_valid_q;
  assign bus.aw_addr  = addr_q;
  assign bus.aw_size  = size_q;
  assign bus.aw_len   = 8'd0;
  assign bus.aw_id    = AXI_ID;
  assign bus.w_valid  = w_valid_q;
  assign bus.w_data   = wdata_q;
  assign bus.w_strb   = wmask_q;
  assign bus.w_last   = w_valid_q;
  assign bus.b_ready  = b_ready_q;
endmodule
